// File: rtl/controle_escrita_reg_pkg.sv
// Shared definitions for the register writeback controller: source select codes,
// FSM state encoding and the mapping from request type to the first state after acceptance.
package escrita_pkg;

    localparam logic [1:0] SEL_ULA = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;
    localparam logic [1:0] SEL_SW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_SW  = 2'd2,
        WRITE    = 2'd3
    } estado_t;

    // ALU and immediate results are already valid on acceptance, so they go straight to WRITE.
    function automatic estado_t estado_apos_aceite(input logic [1:0] tipo);
        case (tipo)
            SEL_MEM: return WAIT_MEM;
            SEL_SW:  return WAIT_SW;
            default: return WRITE;
        endcase
    endfunction

endpackage

// File: rtl/controle_escrita_reg_if.sv
// Request / writeback bundle between the instruction control unit, the memory,
// the operator panel and the writeback controller (slave side = controller).
interface controle_escrita_reg_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_tipo;
    logic [REG_ADDR_W-1:0] req_rd;
    logic                  mem_valid;
    logic                  sw_confirma;
    logic [1:0]            controle;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] reg_rd;
    logic                  aguardando_sw;
    logic                  erro_mem;

    modport master (
        output req_valid, req_tipo, req_rd, mem_valid, sw_confirma,
        input  req_ready, controle, reg_write, reg_rd, aguardando_sw, erro_mem
    );

    modport slave (
        input  req_valid, req_tipo, req_rd, mem_valid, sw_confirma,
        output req_ready, controle, reg_write, reg_rd, aguardando_sw, erro_mem
    );
endinterface

// File: rtl/controle_escrita_reg_debounce.sv
// Confirm-button filter: the output level follows the input only after DEBOUNCE_CYCLES
// consecutive samples that disagree with the current output.
module confirma_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic saida
);

    localparam logic [15:0] LIMITE = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_saida;

    // Any sample equal to the filtered level restarts the stability window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 16'd0;
            r_saida <= 1'b0;
        end else if (entrada == r_saida) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == LIMITE) begin
            r_saida <= entrada;
            r_cnt   <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign saida = r_saida;

endmodule

// File: rtl/controle_escrita_reg.sv
// Register-file writeback sequencer: accepts a request, waits for its source, then issues
// the mux select and a one-cycle write strobe. Macro SW_DEBOUNCE_EN filters the confirm button.
module controle_escrita_reg
    import escrita_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int MEM_TIMEOUT     = 15,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input logic                   clock,
    input logic                   reset,
    controle_escrita_reg_if.slave bus
);

    localparam logic [3:0] TIMEOUT_ULTIMO = 4'(MEM_TIMEOUT - 1);

    estado_t               r_estado;
    logic [1:0]            r_controle;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_reg_rd;
    logic                  r_aguardando_sw;
    logic                  r_erro_mem;
    logic [3:0]            r_cnt_mem;
    logic                  r_sw_anterior;

    logic w_sw_nivel;
    logic w_sw_subida;

`ifdef SW_DEBOUNCE_EN
    confirma_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .entrada(bus.sw_confirma),
        .saida  (w_sw_nivel)
    );
`else
    logic w_unused_debounce;
    assign w_unused_debounce = ^32'(DEBOUNCE_CYCLES);
    assign w_sw_nivel        = bus.sw_confirma;
`endif

    // The previous level is tracked in every state, so a button already held when
    // WAIT_SW is entered never looks like a fresh press.
    assign w_sw_subida = w_sw_nivel & ~r_sw_anterior;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado        <= IDLE;
            r_controle      <= SEL_ULA;
            r_reg_write     <= 1'b0;
            r_reg_rd        <= '0;
            r_aguardando_sw <= 1'b0;
            r_erro_mem      <= 1'b0;
            r_cnt_mem       <= 4'd0;
            r_sw_anterior   <= 1'b0;
        end else begin
            r_reg_write   <= 1'b0;
            r_sw_anterior <= w_sw_nivel;

            case (r_estado)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_controle      <= bus.req_tipo;
                        r_reg_rd        <= bus.req_rd;
                        r_cnt_mem       <= 4'd0;
                        r_estado        <= estado_apos_aceite(bus.req_tipo);
                        r_reg_write     <= (estado_apos_aceite(bus.req_tipo) == WRITE);
                        r_aguardando_sw <= (bus.req_tipo == SEL_SW);
                    end
                end

                // mem_valid is tested first so it wins over a timeout on the same cycle.
                WAIT_MEM: begin
                    if (bus.mem_valid) begin
                        r_estado    <= WRITE;
                        r_reg_write <= 1'b1;
                    end else if (r_cnt_mem == TIMEOUT_ULTIMO) begin
                        r_erro_mem <= 1'b1;
                        r_estado   <= IDLE;
                    end else begin
                        r_cnt_mem <= r_cnt_mem + 4'd1;
                    end
                end

                WAIT_SW: begin
                    if (w_sw_subida) begin
                        r_estado        <= WRITE;
                        r_reg_write     <= 1'b1;
                        r_aguardando_sw <= 1'b0;
                    end
                end

                WRITE: begin
                    r_estado <= IDLE;
                end
            endcase
        end
    end

    // controle and reg_rd are only reloaded on acceptance, so the mux select never glitches.
    assign bus.req_ready     = (r_estado == IDLE);
    assign bus.controle      = r_controle;
    assign bus.reg_write     = r_reg_write;
    assign bus.reg_rd        = r_reg_rd;
    assign bus.aguardando_sw = r_aguardando_sw;
    assign bus.erro_mem      = r_erro_mem;

endmodule

// File: tb/tb_controle_escrita_reg.sv
// Bench for controle_escrita_reg: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations (debounce scenario under SW_DEBOUNCE_EN).
module tb_controle_escrita_reg;

    localparam int AW     = 5;
    localparam int TB_DEB = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    controle_escrita_reg_if #(.REG_ADDR_W(AW)) bus ();

    controle_escrita_reg #(
        .REG_ADDR_W     (AW),
        .MEM_TIMEOUT    (15),
        .DEBOUNCE_CYCLES(TB_DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int w0;
    bit chk_en = 1'b0;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding request, described by its type and how long it has waited.
    bit          m_pend, m_write, m_wait_sw, m_err, m_prev, m_lvl;
    logic [1:0]  m_ctrl;
    logic [AW-1:0] m_rd;
    int          m_waited, m_run;

    always @(posedge clock or negedge reset) begin
        bit lvl;
        if (!reset) begin
            m_pend = 0; m_write = 0; m_wait_sw = 0; m_err = 0; m_prev = 0; m_lvl = 0;
            m_ctrl = 2'b00; m_rd = '0; m_waited = 0; m_run = 0;
        end else begin
`ifdef SW_DEBOUNCE_EN
            lvl = m_lvl;
            if (bus.sw_confirma != m_lvl) begin
                m_run++;
                if (m_run == TB_DEB) begin
                    m_lvl = bus.sw_confirma;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
`else
            lvl = bus.sw_confirma;
`endif
            if (m_write) begin
                m_write = 0;
            end else if (!m_pend) begin
                if (bus.req_valid) begin
                    m_ctrl = bus.req_tipo;
                    m_rd   = bus.req_rd;
                    if (bus.req_tipo == 2'b00 || bus.req_tipo == 2'b10) begin
                        m_write = 1;
                    end else begin
                        m_pend    = 1;
                        m_waited  = 0;
                        m_wait_sw = (bus.req_tipo == 2'b11);
                    end
                end
            end else if (m_ctrl == 2'b01) begin
                if (bus.mem_valid) begin
                    m_write = 1; m_pend = 0;
                end else begin
                    m_waited++;
                    if (m_waited == 15) begin
                        m_err = 1; m_pend = 0;
                    end
                end
            end else if (lvl && !m_prev) begin
                m_write = 1; m_pend = 0; m_wait_sw = 0;
            end
            m_prev = lvl;
        end
    end

    always @(negedge clock) begin
        if (reset && chk_en) begin
            check("mdl_req_ready", 32'(bus.req_ready), 32'(!(m_pend || m_write)));
            check("mdl_controle", 32'(bus.controle), 32'(m_ctrl));
            check("mdl_reg_write", 32'(bus.reg_write), 32'(m_write));
            check("mdl_reg_rd", 32'(bus.reg_rd), 32'(m_rd));
            check("mdl_aguardando_sw", 32'(bus.aguardando_sw), 32'(m_wait_sw));
            check("mdl_erro_mem", 32'(bus.erro_mem), 32'(m_err));
        end
    end

    always @(negedge clock) begin
        if (reset && bus.reg_write === 1'b1) n_writes++;
    end

    // Presents a request for one cycle; returns at the negedge after the acceptance edge.
    task automatic pedir(input logic [1:0] tipo, input logic [AW-1:0] rd);
        bus.req_valid = 1'b1;
        bus.req_tipo  = tipo;
        bus.req_rd    = rd;
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_tipo = 2'b00; bus.req_rd = '0;
        bus.mem_valid = 1'b0; bus.sw_confirma = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_controle", 32'(bus.controle), 32'd0);
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);

        // ALU to r5: strobe the cycle after acceptance, ready again one cycle later
        pedir(2'b00, 5'd5);
        check("alu_write", 32'(bus.reg_write), 32'd1);
        check("alu_ctrl", 32'(bus.controle), 32'd0);
        check("alu_rd", 32'(bus.reg_rd), 32'd5);
        check("alu_ready_low", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        check("alu_write_off", 32'(bus.reg_write), 32'd0);
        check("alu_ready_back", 32'(bus.req_ready), 32'd1);

        // Immediate to r0 is issued like any other register
        pedir(2'b10, 5'd0);
        check("imm_write", 32'(bus.reg_write), 32'd1);
        check("imm_ctrl", 32'(bus.controle), 32'd2);
        @(negedge clock);
        check("imm_ctrl_hold", 32'(bus.controle), 32'd2);

        // req_valid held high: accepted every second cycle
        w0 = n_writes;
        bus.req_valid = 1'b1; bus.req_tipo = 2'b00; bus.req_rd = 5'd7;
        repeat (4) @(negedge clock);
        bus.req_valid = 1'b0;
        check("b2b_writes", 32'(n_writes - w0), 32'd2);
        @(negedge clock);

        // Load to r9, data valid on the 4th waiting cycle; a competing request is ignored
        w0 = n_writes;
        pedir(2'b01, 5'd9);
        check("ld_ctrl", 32'(bus.controle), 32'd1);
        check("ld_wait_write", 32'(bus.reg_write), 32'd0);
        bus.req_valid = 1'b1; bus.req_tipo = 2'b00; bus.req_rd = 5'd3;
        repeat (3) @(negedge clock);
        bus.mem_valid = 1'b1;
        @(negedge clock);
        bus.mem_valid = 1'b0; bus.req_valid = 1'b0;
        check("ld_write", 32'(bus.reg_write), 32'd1);
        check("ld_ctrl_kept", 32'(bus.controle), 32'd1);
        check("ld_rd_kept", 32'(bus.reg_rd), 32'd9);
        check("ld_err", 32'(bus.erro_mem), 32'd0);
        @(negedge clock);
        check("ld_writes", 32'(n_writes - w0), 32'd1);

        // mem_valid on the 15th waiting cycle beats the timeout
        pedir(2'b01, 5'd12);
        repeat (14) @(negedge clock);
        bus.mem_valid = 1'b1;
        @(negedge clock);
        bus.mem_valid = 1'b0;
        check("bnd_write", 32'(bus.reg_write), 32'd1);
        check("bnd_err", 32'(bus.erro_mem), 32'd0);
        @(negedge clock);

        // Timeout: back in IDLE after 15 waiting cycles, error set, no write
        w0 = n_writes;
        pedir(2'b01, 5'd20);
        repeat (14) @(negedge clock);
        check("to_still_waiting", 32'(bus.req_ready), 32'd0);
        @(negedge clock);
        check("to_ready", 32'(bus.req_ready), 32'd1);
        check("to_err", 32'(bus.erro_mem), 32'd1);
        check("to_no_write", 32'(n_writes - w0), 32'd0);

        // Error stays set across a later successful write
        pedir(2'b00, 5'd4);
        check("sticky_write", 32'(bus.reg_write), 32'd1);
        check("sticky_err", 32'(bus.erro_mem), 32'd1);
        @(negedge clock);

`ifndef SW_DEBOUNCE_EN
        // Switch: held on entry is ignored; release and press gives one write
        bus.sw_confirma = 1'b1;
        @(negedge clock);
        w0 = n_writes;
        pedir(2'b11, 5'd17);
        check("sw_wait", 32'(bus.aguardando_sw), 32'd1);
        check("sw_ctrl", 32'(bus.controle), 32'd3);
        repeat (5) @(negedge clock);
        check("sw_held_nowrite", 32'(n_writes - w0), 32'd0);
        bus.sw_confirma = 1'b0;
        @(negedge clock);
        bus.sw_confirma = 1'b1;
        @(negedge clock);
        check("sw_write", 32'(bus.reg_write), 32'd1);
        check("sw_wait_drop", 32'(bus.aguardando_sw), 32'd0);
        check("sw_rd", 32'(bus.reg_rd), 32'd17);
        repeat (2) @(negedge clock);
        bus.sw_confirma = 1'b0;
        check("sw_writes", 32'(n_writes - w0), 32'd1);
        @(negedge clock);
`else
        // Debounced switch: a 3-cycle glitch is filtered, an 8-cycle press gives one write
        w0 = n_writes;
        pedir(2'b11, 5'd11);
        bus.sw_confirma = 1'b1;
        repeat (3) @(negedge clock);
        bus.sw_confirma = 1'b0;
        repeat (12) @(negedge clock);
        check("deb_glitch_nowrite", 32'(n_writes - w0), 32'd0);
        check("deb_still_wait", 32'(bus.aguardando_sw), 32'd1);
        bus.sw_confirma = 1'b1;
        repeat (11) @(negedge clock);
        check("deb_one_write", 32'(n_writes - w0), 32'd1);
        bus.sw_confirma = 1'b0;
        repeat (10) @(negedge clock);
        check("deb_writes_final", 32'(n_writes - w0), 32'd1);
        check("deb_ready", 32'(bus.req_ready), 32'd1);
`endif

        // Reset in the middle of a load wait discards the request
        pedir(2'b01, 5'd22);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rstmid_ctrl", 32'(bus.controle), 32'd0);
        check("rstmid_rd", 32'(bus.reg_rd), 32'd0);
        check("rstmid_write", 32'(bus.reg_write), 32'd0);
        check("rstmid_err", 32'(bus.erro_mem), 32'd0);
        check("rstmid_wait", 32'(bus.aguardando_sw), 32'd0);
        check("rstmid_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        w0 = n_writes;
        bus.mem_valid = 1'b1;
        repeat (3) @(negedge clock);
        bus.mem_valid = 1'b0;
        check("rstmid_no_write", 32'(n_writes - w0), 32'd0);
        @(negedge clock);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
